// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: instruction-memory fetch bus between the PC sequencer and instruction memory.
//   req  : fetch request (master -> slave)
//   addr : fetch address (master -> slave)
//   ack  : fetch completion, meaningful only while req=1 (slave -> master)
interface pc_sequencer_if #(parameter int PC_WIDTH = 32);
  logic                req;
  logic [PC_WIDTH-1:0] addr;
  logic                ack;
  modport master (output req, addr, input ack);
  modport slave  (input req, addr, output ack);
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: IDLE/FETCH/FLUSH program-counter sequencer with branch/jump redirect and pipeline flush.
//   clock, reset (sync, active-low) ; pc_src/branch_target/jump_target select the next PC ;
//   stall holds decode ; imem is the fetch bus master ; pc, fetch_valid, flush are status outputs.
module pc_sequencer #(
  parameter int                  PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] BOOT_ADDR    = '0,
  parameter int                  FLUSH_CYCLES = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          pc_src,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic                stall,
  pc_sequencer_if.master      imem,
  output logic [PC_WIDTH-1:0] pc,
  output logic                fetch_valid,
  output logic                flush
);
  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;
  state_t              state;
  logic [3:0]          cnt;
  logic                req;
  logic                redirect;
  logic [PC_WIDTH-1:0] target;
  // pc_src=11 falls through as sequential; redirects are ignored in IDLE
  assign redirect    = (state != IDLE) & (pc_src == 2'b01 | pc_src == 2'b10);
  assign target      = (pc_src == 2'b01 ? branch_target : jump_target) & ~PC_WIDTH'(3);
  // gated by reset so no acceptance is reported on the edge that abandons a fetch
  assign fetch_valid = reset & (state == FETCH) & imem.ack & ~stall & ~redirect;
  assign imem.req    = req;
  assign imem.addr   = pc;
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      pc    <= BOOT_ADDR;
      cnt   <= '0;
      req   <= 1'b0;
      flush <= 1'b0;
    end else if (redirect) begin
      state <= FLUSH;
      pc    <= target;
      cnt   <= 4'(FLUSH_CYCLES - 1);
      req   <= 1'b0;
      flush <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          state <= FETCH;
          req   <= 1'b1;
        end
        FETCH: if (fetch_valid) pc <= pc + PC_WIDTH'(4);
        FLUSH: begin
          if (cnt == '0) begin
            state <= FETCH;
            req   <= 1'b1;
            flush <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer (default boot and wrap-around boot instances).
module tb_pc_sequencer;
  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  pc_src;
  logic [31:0] branch_target, jump_target;
  logic        stall, ack;
  logic [31:0] pc, pc2;
  logic        fetch_valid, fetch_valid2, flush, flush2;
  int          vectors = 0;
  int          errors  = 0;

  pc_sequencer_if #(.PC_WIDTH(32)) bus ();
  pc_sequencer_if #(.PC_WIDTH(32)) bus2 ();
  assign bus.ack  = ack;
  assign bus2.ack = ack;

  pc_sequencer #(.PC_WIDTH(32), .BOOT_ADDR(32'h0), .FLUSH_CYCLES(2)) dut (
    .clock(clock), .reset(reset), .pc_src(pc_src), .branch_target(branch_target),
    .jump_target(jump_target), .stall(stall), .imem(bus.master), .pc(pc),
    .fetch_valid(fetch_valid), .flush(flush));

  pc_sequencer #(.PC_WIDTH(32), .BOOT_ADDR(32'hFFFF_FFFC), .FLUSH_CYCLES(2)) dut2 (
    .clock(clock), .reset(reset), .pc_src(pc_src), .branch_target(branch_target),
    .jump_target(jump_target), .stall(stall), .imem(bus2.master), .pc(pc2),
    .fetch_valid(fetch_valid2), .flush(flush2));

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; pc_src = 2'b00; branch_target = '0; jump_target = '0; stall = 1'b0; ack = 1'b1;
    tick; tick;
    chk("rst_req", 32'(bus.req), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_addr", bus.addr, 32'h0);
    chk("rst_fv", 32'(fetch_valid), 32'd0);
    chk("rst_pc2", pc2, 32'hFFFF_FFFC);
    chk("rst_addr2", bus2.addr, 32'hFFFF_FFFC);
    reset = 1'b1;
    #1;
    chk("idle_req", 32'(bus.req), 32'd0);
    tick;
    chk("seq_req", 32'(bus.req), 32'd1);
    chk("seq_fv0", 32'(fetch_valid), 32'd1);
    chk("seq_pc0", pc, 32'h0);
    chk("wrap_fv", 32'(fetch_valid2), 32'd1);
    chk("wrap_pc_pre", pc2, 32'hFFFF_FFFC);
    tick;
    chk("seq_pc4", pc, 32'h4);
    chk("wrap_pc", pc2, 32'h0);
    tick;
    chk("seq_pc8", pc, 32'h8);
    chk("seq_fv8", 32'(fetch_valid), 32'd1);
    tick;
    chk("seq_pcC", pc, 32'hC);
    tick;
    chk("seq_pc10", pc, 32'h10);
    // branch taken with simultaneous ack
    pc_src = 2'b01; branch_target = 32'h103;
    #1;
    chk("br_fv", 32'(fetch_valid), 32'd0);
    tick;
    pc_src = 2'b00;
    chk("br_pc", pc, 32'h100);
    chk("br_flush1", 32'(flush), 32'd1);
    chk("br_req1", 32'(bus.req), 32'd0);
    chk("br_fv1", 32'(fetch_valid), 32'd0);
    tick;
    chk("br_flush2", 32'(flush), 32'd1);
    chk("br_req2", 32'(bus.req), 32'd0);
    tick;
    chk("br_flush3", 32'(flush), 32'd0);
    chk("br_req3", 32'(bus.req), 32'd1);
    chk("br_addr", bus.addr, 32'h100);
    // jump to 0x20 for the stall scenario
    pc_src = 2'b10; jump_target = 32'h20;
    tick;
    pc_src = 2'b00;
    tick; tick;
    stall = 1'b1;
    #1;
    chk("st_req", 32'(bus.req), 32'd1);
    chk("st_fv1", 32'(fetch_valid), 32'd0);
    chk("st_pc1", pc, 32'h20);
    tick;
    chk("st_fv2", 32'(fetch_valid), 32'd0);
    chk("st_pc2", pc, 32'h20);
    tick;
    chk("st_fv3", 32'(fetch_valid), 32'd0);
    chk("st_addr3", bus.addr, 32'h20);
    tick;
    stall = 1'b0;
    #1;
    chk("st_release_fv", 32'(fetch_valid), 32'd1);
    tick;
    chk("st_pc24", pc, 32'h24);
    // jump to 0x80 then re-jump to 0x200 in flush cycle 1
    pc_src = 2'b10; jump_target = 32'h80;
    tick;
    chk("jj_pc80", pc, 32'h80);
    chk("jj_flush_a", 32'(flush), 32'd1);
    jump_target = 32'h202;
    tick;
    pc_src = 2'b00;
    chk("jj_pc200", pc, 32'h200);
    chk("jj_flush_b", 32'(flush), 32'd1);
    tick;
    chk("jj_flush_c", 32'(flush), 32'd1);
    chk("jj_req_c", 32'(bus.req), 32'd0);
    tick;
    chk("jj_flush_d", 32'(flush), 32'd0);
    chk("jj_req_d", 32'(bus.req), 32'd1);
    chk("jj_addr", bus.addr, 32'h200);
    // reserved pc_src acts as sequential
    pc_src = 2'b11;
    #1;
    chk("rsv_fv", 32'(fetch_valid), 32'd1);
    tick;
    pc_src = 2'b00;
    chk("rsv_pc", pc, 32'h204);
    chk("rsv_flush", 32'(flush), 32'd0);
    // no ack: pc holds
    ack = 1'b0;
    #1;
    chk("noack_fv", 32'(fetch_valid), 32'd0);
    tick;
    chk("noack_pc", pc, 32'h204);
    ack = 1'b1;
    // reset during flush cycle 1
    pc_src = 2'b10; jump_target = 32'h300;
    tick;
    pc_src = 2'b00;
    chk("rf_flush", 32'(flush), 32'd1);
    reset = 1'b0;
    #1;
    chk("rf_fv", 32'(fetch_valid), 32'd0);
    tick;
    chk("rf_flush0", 32'(flush), 32'd0);
    chk("rf_req0", 32'(bus.req), 32'd0);
    chk("rf_pc", pc, 32'h0);
    chk("rf_fv0", 32'(fetch_valid), 32'd0);
    reset = 1'b1;
    tick;
    chk("rf_req1", 32'(bus.req), 32'd1);
    chk("rf_addr", bus.addr, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
